// File: rtl/spi_pkg.sv
// Shared constants for the SPI mode-0 slave.
// Frame width and bit-counter width used by spi_slave.
package spi_pkg;

   localparam int SPI_WIDTH = 8;
   localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with a selectable reset level.
// Ports: clk, rst (sync, active high), rst_val, d (async in), q (synced out).
module spi_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic rst_val,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{rst_val}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, 8-bit MSB-first frames, oversampled in the clk domain.
// Ports: clk, rst, ss/sck/mosi (async pins), miso, din (tx byte),
//        done (1-clk rx pulse), dout (last rx byte).
module spi_slave
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ss,
   input  logic                 sck,
   input  logic                 mosi,
   output logic                 miso,
   input  logic [SPI_WIDTH-1:0] din,
   output logic                 done,
   output logic [SPI_WIDTH-1:0] dout
);

   localparam logic [BIT_CNT_W-1:0] LAST_BIT =
      BIT_CNT_W'(SPI_WIDTH - 1);

   logic ss_s;
   logic sck_s;
   logic mosi_s;

   logic                 sck_prev_q;
   logic                 sck_prev_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q;
   logic [BIT_CNT_W-1:0] bit_cnt_d;
   logic [SPI_WIDTH-1:0] shift_q;
   logic [SPI_WIDTH-1:0] shift_d;
   logic [SPI_WIDTH-1:0] dout_q;
   logic [SPI_WIDTH-1:0] dout_d;
   logic                 done_q;
   logic                 done_d;
   logic                 miso_q;
   logic                 miso_d;

   logic sck_rise;
   logic sck_fall;
   logic [SPI_WIDTH-1:0] shift_in;

   // ss idles high so an unsynchronized start reads as "not selected".
   spi_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync_ss (
      .clk     (clk),
      .rst     (rst),
      .rst_val (1'b1),
      .d       (ss),
      .q       (ss_s)
   );

   spi_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync_sck (
      .clk     (clk),
      .rst     (rst),
      .rst_val (1'b0),
      .d       (sck),
      .q       (sck_s)
   );

   spi_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync_mosi (
      .clk     (clk),
      .rst     (rst),
      .rst_val (1'b0),
      .d       (mosi),
      .q       (mosi_s)
   );

   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign shift_in = {shift_q[SPI_WIDTH-2:0], mosi_s};

   always_comb begin
      sck_prev_d = sck_s;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      dout_d     = dout_q;
      done_d     = 1'b0;
      miso_d     = miso_q;

      if (ss_s) begin
         // Deselected: keep tracking din so the first bit is
         // already on miso when the master pulls ss low.
         bit_cnt_d = '0;
         shift_d   = din;
         miso_d    = din[SPI_WIDTH-1];
      end else if (sck_rise) begin
         shift_d   = shift_in;
         bit_cnt_d = bit_cnt_q + 1'b1;
         if (bit_cnt_q == LAST_BIT) begin
            dout_d  = shift_in;
            done_d  = 1'b1;
            // Reload so a back-to-back byte transmits din again.
            shift_d = din;
         end
      end else if (sck_fall) begin
         miso_d = shift_q[SPI_WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_prev_q <= 1'b0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         dout_q     <= '0;
         done_q     <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         sck_prev_q <= sck_prev_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         dout_q     <= dout_d;
         done_q     <= done_d;
         miso_q     <= miso_d;
      end
   end

   assign miso = miso_q;
   assign done = done_q;
   assign dout = dout_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave.
// Drives SPI mode-0 frames aligned to clk and checks rx/tx behaviour.
module tb_spi_slave;

   logic       clk = 1'b0;
   logic       rst;
   logic       ss;
   logic       sck;
   logic       mosi;
   logic       miso;
   logic [7:0] din;
   logic       done;
   logic [7:0] dout;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int rise_cyc = 0;
   int base     = 0;
   bit done_prev = 1'b0;
   bit dbl       = 1'b0;
   logic [7:0] dq[$];
   logic [7:0] m0;
   logic [7:0] m1;

   spi_slave #(
      .SYNC_STAGES (2)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .ss   (ss),
      .sck  (sck),
      .mosi (mosi),
      .miso (miso),
      .din  (din),
      .done (done),
      .dout (dout)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
         dq.push_back(dout);
         if (done_prev) dbl = 1'b1;
      end
      done_prev = (done === 1'b1);
   end

   initial begin
      #1ms;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One sck pulse: mosi set while low, miso sampled at the rise.
   task automatic pulse(input logic b, input int lo, input int hi,
                        output logic smp);
      mosi = b;
      tick(lo);
      smp = miso;
      rise_cyc = cyc;
      sck = 1'b1;
      tick(hi);
      sck = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic [7:0] rx);
      logic m;
      for (int i = 7; i >= 0; i--) begin
         pulse(b[i], 3, 2, m);
         rx[i] = m;
      end
   endtask

   task automatic frame(input logic [7:0] b, output logic [7:0] rx);
      ss = 1'b0;
      tick(4);
      send_byte(b, rx);
      tick(6);
      ss = 1'b1;
      tick(6);
   endtask

   initial begin
      logic m;
      rst  = 1'b1;
      ss   = 1'b1;
      sck  = 1'b0;
      mosi = 1'b0;
      din  = 8'h00;
      tick(5);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_dout", 32'(dout), 32'h00);
      chk("rst_miso", 32'(miso), 32'h0);
      rst = 1'b0;
      tick(20);
      chk("idle_no_done", done_cnt, 0);

      // Single byte 0xED at 10 MHz sck.
      base = done_cnt;
      ss = 1'b0;
      tick(4);
      send_byte(8'hED, m0);
      tick(6);
      chk("b1_done_cnt", done_cnt - base, 1);
      chk("b1_latency", done_cyc - rise_cyc, 3);
      chk("b1_dout", 32'(dout), 32'hED);
      ss = 1'b1;

      // Second frame after 1 us idle.
      tick(50);
      chk("b2_hold", 32'(dout), 32'hED);
      base = done_cnt;
      frame(8'hB7, m0);
      chk("b2_done_cnt", done_cnt - base, 1);
      chk("b2_dout", 32'(dout), 32'hB7);

      // Transmit din=0xA5 while receiving 0x5A.
      din = 8'hA5;
      tick(10);
      chk("tx_idle_miso", 32'(miso), 32'h1);
      base = done_cnt;
      frame(8'h5A, m0);
      chk("tx_miso_bits", 32'(m0), 32'hA5);
      chk("tx_rx_dout", 32'(dout), 32'h5A);
      chk("tx_done_cnt", done_cnt - base, 1);

      // Abort after 5 bits, then a full 0x3C frame.
      din = 8'h00;
      tick(4);
      base = done_cnt;
      ss = 1'b0;
      tick(4);
      repeat (5) pulse(1'b1, 3, 2, m);
      tick(6);
      ss = 1'b1;
      tick(10);
      chk("abort_no_done", done_cnt - base, 0);
      chk("abort_dout", 32'(dout), 32'h5A);
      frame(8'h3C, m0);
      chk("abort_done_cnt", done_cnt - base, 1);
      chk("abort_dout2", 32'(dout), 32'h3C);

      // Reset in the middle of a frame.
      ss = 1'b0;
      tick(4);
      repeat (3) pulse(1'b1, 3, 2, m);
      rst = 1'b1;
      ss  = 1'b1;
      tick(2);
      chk("mid_rst_dout", 32'(dout), 32'h00);
      chk("mid_rst_done", 32'(done), 32'h0);
      chk("mid_rst_miso", 32'(miso), 32'h0);
      rst = 1'b0;
      tick(10);

      // Back-to-back 0x12, 0x34 with din=0x56.
      din = 8'h56;
      tick(10);
      dq.delete();
      ss = 1'b0;
      tick(4);
      send_byte(8'h12, m0);
      send_byte(8'h34, m1);
      tick(6);
      ss = 1'b1;
      tick(6);
      chk("b2b_count", dq.size(), 2);
      if (dq.size() == 2) begin
         chk("b2b_dout0", 32'(dq[0]), 32'h12);
         chk("b2b_dout1", 32'(dq[1]), 32'h34);
      end
      chk("b2b_miso0", 32'(m0), 32'h56);
      chk("b2b_miso1", 32'(m1), 32'h56);
      chk("b2b_final_dout", 32'(dout), 32'h34);

      chk("done_single_cycle", 32'(dbl), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
